tt_um_hoene_led_pwm_multi: RTL and testbench
============================================

# tt_um_hoene_led_pwm_multi

Parametrised multi-channel LED PWM generator with double-buffered duty registers and a linear fade engine. It takes the place of the fixed three-channel 10-bit PWM at the end of the smart-LED receive chain. It is fed by the serial-to-parallel stage (`data_in`, with `store` pulsed when a frame closes) and drives the LED pins. New duties take effect only at PWM period boundaries, either immediately or ramped one LSB per step.

## Interface
- `CHANNELS`, 3: number of PWM outputs.
- `WIDTH`, 10: duty resolution in bits; PWM period is 2^WIDTH−1 clocks.
- `FADE_DIV_WIDTH`, 8: width of the fade step divider.

- `clk` in 1: clock.
- `rst` in 1: reset. Single clock; reset is synchronous and active-high.
- `data_in` in CHANNELS*WIDTH: target duties; channel i occupies bits [i*WIDTH +: WIDTH].
- `store` in 1: one-cycle strobe that captures `data_in` into the target registers.
- `mode` in 2: 00 direct, 01 fade, 10 blank, 11 test.
- `fade_div` in FADE_DIV_WIDTH: number of PWM periods per fade step, minus 1.
- `pwm_out` out CHANNELS: LED drive, active high.
- `period_start` out 1: one-cycle pulse marking the first cycle of each PWM period.
- `busy` out 1: high while any current duty differs from its target.

## Operation
- Period counter `cnt` (WIDTH bits) counts 0 … 2^WIDTH−2, then wraps to 0.
- The wrap edge is the clock edge at which `cnt`==2^WIDTH−2.
- Per channel there are two registers: `target` (shadow) and `cur` (active).
- `store`=1: `target[i]` <= `data_in` slice on that edge.
- `store` has no effect on `cur` except through the wrap-edge rules below.
- `cur` changes only on the wrap edge:
  - mode 00 (direct): `cur` <= `target`.
  - mode 01 (fade): fade counter `fcnt` is compared against `fade_div`.
    - If `fcnt`==`fade_div`: `fcnt` <= 0, and each `cur` steps ±1 toward its `target`; `cur` is unchanged where equal.
    - Otherwise `fcnt`++.
  - mode 10 and 11: `cur` and `fcnt` hold.
- Output compare: `pwm_out[i]` = (`cnt` < `cur[i]`), registered.
  - Duty 0 gives a constant low output.
  - Duty 2^WIDTH−1 gives a constant high output.
- Mode 10 (blank) forces all `pwm_out` to 0. Mode 11 (test) forces all `pwm_out` to 1. `cnt` keeps running in both modes.
- Leaving fade for direct mid-ramp: `cur` jumps to `target` at the next wrap edge. `fcnt` holds its value.
- `store` on the wrap edge itself: the wrap update uses the old `target`. The new `target` applies from the following wrap edge.
- `mode` is sampled every cycle, with no synchronisation inside the block.
- `fade_div` is sampled on the wrap edge.
- `rst` mid-operation: all state clears on that edge and the next period starts from `cnt`=0.

## Timing
- Reset values: `cnt`=0, `fcnt`=0, all `target`=0, all `cur`=0, `pwm_out`=0, `period_start`=0, `busy`=0.
- All outputs are registered and lag `cnt` by exactly 1 cycle.
  - `period_start` <= (`cnt`==0).
  - `busy` <= OR over i of (`cur[i]` != `target[i]`).
- Latency from `store` to the new duty at the output:
  - Direct mode: the first period beginning after the next wrap edge.
  - Fade mode: |target−cur| steps, each (`fade_div`+1) periods.
- Outputs never glitch: at most one `pwm_out` transition per channel per period.

## Structure
- Package `tt_um_hoene_led_pkg` holds the mode encodings: `MODE_DIRECT`, `MODE_FADE`, `MODE_BLANK`, `MODE_TEST`.
- Sub-module `tt_um_hoene_pwm_channel` holds one channel's `target`/`cur` registers, the step logic and the compare. It takes `cnt`, `wrap`, `step_en`, `mode` and the duty slice.
- The top level owns `cnt`, `fcnt`, `period_start` and the busy OR-reduction, and generates CHANNELS channel instances.

## Test plan
The bench uses WIDTH=4, so the period is 15 cycles.
1. Reset: hold `rst` 3 cycles with random inputs.
   - Expect all outputs 0 during reset.
   - After release, expect `period_start` every 15 cycles and `pwm_out`=000.
2. Direct mode: `store` ch0=5, ch1=15, ch2=0.
   - Starting at the first period after the wrap, expect ch0 high for 5 of every 15 cycles, ch1 constantly high, ch2 constantly low.
3. Fade mode, `fade_div`=0, `cur`=0: `store` ch0=3.
   - Expect ch0 duties 1, 2, 3 in successive periods.
   - Expect `busy`=1 until `cur`=3, then 0.
   - Then `store` ch0=1: expect duties 2, 1.
4. Fade mode, `fade_div`=2.
   - Expect `cur` to step only every 3rd period.
   - Switch to direct mid-ramp: expect a jump to `target` at the next wrap.
5. `store` asserted on the wrap edge.
   - Expect the old target applied for that period and the new target one period later.
6. Blank and test modes.
   - Mode 10: expect `pwm_out`=000. Mode 11: expect `pwm_out`=111.
   - On return to 00, expect the prior duties unchanged.
   - Assert `rst` during a fade: expect all `cur` and `target` to be 0 on the next cycle.

Source files
------------

// File: rtl/tt_um_hoene_led_pkg.sv
// Shared definitions for the multi-channel LED PWM generator.
// Mode encodings as seen on the mode input.
package tt_um_hoene_led_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_FADE   = 2'b01,
    MODE_BLANK  = 2'b10,
    MODE_TEST   = 2'b11
  } mode_e;

endpackage

// File: rtl/tt_um_hoene_led_pwm_multi_if.sv
// Bus between the serial-to-parallel stage and the LED PWM block.
// The master drives duties and control; the slave returns LED drive and status.
interface tt_um_hoene_led_pwm_multi_if #(
  parameter int CHANNELS       = 3,
  parameter int WIDTH          = 10,
  parameter int FADE_DIV_WIDTH = 8
);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic                      store;
  logic [1:0]                mode;
  logic [FADE_DIV_WIDTH-1:0] fade_div;
  logic [CHANNELS-1:0]       pwm_out;
  logic                      period_start;
  logic                      busy;

  modport master (
    output data_in, store, mode, fade_div,
    input  pwm_out, period_start, busy
  );

  modport slave (
    input  data_in, store, mode, fade_div,
    output pwm_out, period_start, busy
  );

endinterface

// File: rtl/tt_um_hoene_pwm_channel.sv
// One PWM channel: shadow target, active duty, fade step and compare.
// The active duty only moves on the period wrap edge.
module tt_um_hoene_pwm_channel
  import tt_um_hoene_led_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic             step_en_i,
  input  mode_e            mode_i,
  input  logic             store_i,
  input  logic [WIDTH-1:0] duty_i,
  output logic             pwm_o,
  output logic             diff_o
);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    target_d = store_i ? duty_i : target_q;
    cur_d    = cur_q;
    if (wrap_i) begin
      unique case (mode_i)
        MODE_DIRECT: cur_d = target_q;
        MODE_FADE: begin
          if (step_en_i) begin
            if (cur_q < target_q)
              cur_d = cur_q + 1'b1;
            else if (cur_q > target_q)
              cur_d = cur_q - 1'b1;
          end
        end
        default: cur_d = cur_q;
      endcase
    end
  end

  always_comb begin
    pwm_d = 1'b0;
    unique case (mode_i)
      MODE_BLANK: pwm_d = 1'b0;
      MODE_TEST:  pwm_d = 1'b1;
      default:    pwm_d = (cnt_i < cur_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= '0;
      cur_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o  = pwm_q;
  assign diff_o = (cur_q != target_q);

endmodule

// File: rtl/tt_um_hoene_led_pwm_multi.sv
// Multi-channel LED PWM with double-buffered duties and linear fade.
// Owns the period counter, fade divider and status outputs.
module tt_um_hoene_led_pwm_multi
  import tt_um_hoene_led_pkg::*;
#(
  parameter int CHANNELS       = 3,
  parameter int WIDTH          = 10,
  parameter int FADE_DIV_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  tt_um_hoene_led_pwm_multi_if.slave bus
);

  // Last count value before the wrap: 2^WIDTH-2.
  localparam logic [WIDTH-1:0] CNT_LAST =
    {{(WIDTH-1){1'b1}}, 1'b0};

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [FADE_DIV_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                      ps_q;
  logic                      busy_q;
  logic                      wrap;
  logic                      step_en;
  mode_e                     mode;
  logic [CHANNELS-1:0]       diff;
  logic [CHANNELS-1:0]       pwm;

  assign mode    = mode_e'(bus.mode);
  assign wrap    = (cnt_q == CNT_LAST);
  assign step_en = wrap && (mode == MODE_FADE) &&
                   (fcnt_q == bus.fade_div);

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    fcnt_d = fcnt_q;
    if (wrap && (mode == MODE_FADE))
      fcnt_d = step_en ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      ps_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      ps_q   <= (cnt_q == '0);
      busy_q <= |diff;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tt_um_hoene_pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .cnt_i    (cnt_q),
      .wrap_i   (wrap),
      .step_en_i(step_en),
      .mode_i   (mode),
      .store_i  (bus.store),
      .duty_i   (bus.data_in[i*WIDTH +: WIDTH]),
      .pwm_o    (pwm[i]),
      .diff_o   (diff[i])
    );
  end

  assign bus.pwm_out      = pwm;
  assign bus.period_start = ps_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_tt_um_hoene_led_pwm_multi.sv
// Bench for the multi-channel LED PWM generator (WIDTH=4, period 15).
// Random stimulus checked against a period-level behavioural model.
module tb_tt_um_hoene_led_pwm_multi;

  localparam int CH  = 3;
  localparam int W   = 4;
  localparam int FW  = 8;
  localparam int PER = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tt_um_hoene_led_pwm_multi_if #(
    .CHANNELS(CH), .WIDTH(W), .FADE_DIV_WIDTH(FW)
  ) bus ();

  tt_um_hoene_led_pwm_multi #(
    .CHANNELS(CH), .WIDTH(W), .FADE_DIV_WIDTH(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_cnt = 0;
  int m_fcnt = 0;
  int m_tgt[CH] = '{0, 0, 0};
  int m_cur[CH] = '{0, 0, 0};
  logic [4:0] exp_out;

  function automatic logic [4:0] obs();
    return {bus.pwm_out, bus.period_start, bus.busy};
  endfunction

  // Advance one clock; exp_out holds what the outputs must show after it.
  task automatic step();
    logic [2:0] ep;
    logic eps, eb;
    int m;
    m = int'(bus.mode);
    eb = 1'b0;
    for (int i = 0; i < CH; i++) begin
      ep[i] = (m_cnt < m_cur[i]);
      if (m_cur[i] != m_tgt[i]) eb = 1'b1;
    end
    if (m == 2) ep = 3'b000;
    if (m == 3) ep = 3'b111;
    eps = (m_cnt == 0);
    if (rst) begin
      ep = '0; eps = 1'b0; eb = 1'b0;
      m_cnt = 0; m_fcnt = 0;
      for (int i = 0; i < CH; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0;
      end
    end else begin
      if (m_cnt == PER - 1) begin
        if (m == 0) begin
          for (int i = 0; i < CH; i++) m_cur[i] = m_tgt[i];
        end else if (m == 1) begin
          if (m_fcnt == int'(bus.fade_div)) begin
            m_fcnt = 0;
            for (int i = 0; i < CH; i++) begin
              if (m_cur[i] < m_tgt[i]) m_cur[i]++;
              else if (m_cur[i] > m_tgt[i]) m_cur[i]--;
            end
          end else begin
            m_fcnt = (m_fcnt + 1) % 256;
          end
        end
      end
      m_cnt = (m_cnt + 1) % PER;
      if (bus.store)
        for (int i = 0; i < CH; i++)
          m_tgt[i] = int'(bus.data_in[i*W +: W]);
    end
    @(posedge clk);
    #1;
    exp_out = {ep, eps, eb};
  endtask

  task automatic set_duty(input int d0, input int d1, input int d2);
    bus.data_in = {4'(d2), 4'(d1), 4'(d0)};
  endtask

  // Measure one full aligned period: high counts, busy seen, model mismatches.
  task automatic measure(output int hi[CH], output bit bz, output int mm);
    int guard;
    guard = 0;
    hi = '{0, 0, 0};
    bz = 1'b0;
    mm = 0;
    step();
    if (obs() !== exp_out) mm++;
    while (bus.period_start !== 1'b1 && guard < 30) begin
      step();
      if (obs() !== exp_out) mm++;
      guard++;
    end
    if (guard >= 30) mm += 1000;
    for (int k = 0; k < PER; k++) begin
      if (k > 0) begin
        step();
        if (obs() !== exp_out) mm++;
      end
      for (int i = 0; i < CH; i++) hi[i] += int'(bus.pwm_out[i]);
      if (bus.busy) bz = 1'b1;
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.data_in  = 12'($urandom);
      bus.store    = 1'($urandom);
      bus.mode     = 2'($urandom);
      bus.fade_div = 8'($urandom);
      step();
      checks++;
      if (obs() !== 5'b0) begin
        errors++;
        $display("FAIL reset_outs cyc=%0d got=%b want=00000", k, obs());
      end
    end
    rst = 1'b0;
    bus.store = 1'b0;
    bus.mode = 2'b00;
    bus.fade_div = 8'd0;
    set_duty(0, 0, 0);
    pulses = 0;
    for (int k = 0; k < 3 * PER; k++) begin
      step();
      pulses += int'(bus.period_start);
      checks++;
      if (obs() !== exp_out || bus.pwm_out !== 3'b000) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%b want=%b", k, obs(), exp_out);
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL period_pulses got=%0d want=3", pulses);
    end
  endtask

  task automatic test_direct();
    int hi[CH];
    bit bz;
    int mm;
    measure(hi, bz, mm);
    bus.mode = 2'b00;
    set_duty(5, 15, 0);
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    checks++;
    if (obs() !== exp_out) begin
      errors++;
      $display("FAIL direct_store got=%b want=%b", obs(), exp_out);
    end
    for (int p = 0; p < 2; p++) begin
      measure(hi, bz, mm);
      checks++;
      if (hi[0] != 5 || hi[1] != 15 || hi[2] != 0 || mm != 0) begin
        errors++;
        $display("FAIL direct_duty p=%0d got=%0d/%0d/%0d mm=%0d want=5/15/0 mm=0",
                 p, hi[0], hi[1], hi[2], mm);
      end
    end
  endtask

  task automatic test_fade_div0();
    int hi[CH];
    bit bz;
    int mm;
    int want[5] = '{1, 2, 3, 2, 1};
    bit wbz[5] = '{1, 1, 0, 1, 0};
    set_duty(0, 0, 0);
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    measure(hi, bz, mm);
    checks++;
    if (hi[0] != 0 || hi[1] != 0 || hi[2] != 0 || mm != 0) begin
      errors++;
      $display("FAIL fade_setup got=%0d/%0d/%0d mm=%0d want=0/0/0 mm=0",
               hi[0], hi[1], hi[2], mm);
    end
    bus.mode = 2'b01;
    bus.fade_div = 8'd0;
    for (int p = 0; p < 5; p++) begin
      if (p == 0 || p == 3) begin
        set_duty(p == 0 ? 3 : 1, 0, 0);
        bus.store = 1'b1;
        step();
        bus.store = 1'b0;
      end
      measure(hi, bz, mm);
      checks++;
      if (hi[0] != want[p] || bz != wbz[p] || mm != 0) begin
        errors++;
        $display("FAIL fade0 p=%0d duty=%0d busy=%0d mm=%0d want duty=%0d busy=%0d mm=0",
                 p, hi[0], bz, mm, want[p], wbz[p]);
      end
    end
  endtask

  task automatic test_fade_div2();
    int hi[CH];
    bit bz;
    int mm;
    int want[6] = '{1, 1, 2, 2, 2, 7};
    bus.mode = 2'b01;
    bus.fade_div = 8'd2;
    set_duty(7, $urandom_range(0, 15), $urandom_range(0, 15));
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p == 4) bus.mode = 2'b00;
      measure(hi, bz, mm);
      checks++;
      if (hi[0] != want[p] || mm != 0) begin
        errors++;
        $display("FAIL fade2 p=%0d duty=%0d mm=%0d want=%0d mm=0",
                 p, hi[0], mm, want[p]);
      end
    end
  endtask

  task automatic test_store_on_wrap();
    int hi[CH];
    bit bz;
    int mm;
    int guard;
    logic [11:0] d;
    d = bus.data_in;
    bus.data_in = {d[11:4], 4'd4};
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    guard = 0;
    while (m_cnt != PER - 1 && guard < 20) begin
      step();
      guard++;
      checks++;
      if (obs() !== exp_out) begin
        errors++;
        $display("FAIL wrap_lead got=%b want=%b", obs(), exp_out);
      end
    end
    bus.data_in = {d[11:4], 4'd9};
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    for (int p = 0; p < 2; p++) begin
      measure(hi, bz, mm);
      checks++;
      if (hi[0] != (p == 0 ? 4 : 9) || mm != 0) begin
        errors++;
        $display("FAIL store_wrap p=%0d duty=%0d mm=%0d want=%0d mm=0",
                 p, hi[0], mm, p == 0 ? 4 : 9);
      end
    end
  endtask

  task automatic test_blank_test_reset();
    int hi[CH];
    bit bz;
    int mm;
    int r1, r2;
    r1 = int'(bus.data_in[7:4]);
    r2 = int'(bus.data_in[11:8]);
    bus.mode = 2'b10;
    measure(hi, bz, mm);
    checks++;
    if (hi[0] != 0 || hi[1] != 0 || hi[2] != 0 || mm != 0) begin
      errors++;
      $display("FAIL blank got=%0d/%0d/%0d mm=%0d want=0/0/0", hi[0], hi[1], hi[2], mm);
    end
    bus.mode = 2'b11;
    measure(hi, bz, mm);
    checks++;
    if (hi[0] != 15 || hi[1] != 15 || hi[2] != 15 || mm != 0) begin
      errors++;
      $display("FAIL test_mode got=%0d/%0d/%0d mm=%0d want=15/15/15", hi[0], hi[1], hi[2], mm);
    end
    bus.mode = 2'b00;
    measure(hi, bz, mm);
    checks++;
    if (hi[0] != 9 || hi[1] != r1 || hi[2] != r2 || mm != 0) begin
      errors++;
      $display("FAIL resume got=%0d/%0d/%0d mm=%0d want=9/%0d/%0d",
               hi[0], hi[1], hi[2], mm, r1, r2);
    end
    bus.mode = 2'b01;
    bus.fade_div = 8'd0;
    set_duty($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 15));
    bus.store = 1'b1;
    step();
    bus.store = 1'b0;
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs() !== 5'b0) begin
      errors++;
      $display("FAIL rst_fade got=%b want=00000", obs());
    end
    step();
    checks++;
    if (obs() !== 5'b00010) begin
      errors++;
      $display("FAIL rst_restart got=%b want=00010", obs());
    end
    measure(hi, bz, mm);
    checks++;
    if (hi[0] != 0 || hi[1] != 0 || hi[2] != 0 || bz || mm != 0) begin
      errors++;
      $display("FAIL rst_cleared got=%0d/%0d/%0d busy=%0d mm=%0d want=0/0/0 busy=0",
               hi[0], hi[1], hi[2], bz, mm);
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      bus.store = ($urandom_range(0, 7) == 0);
      bus.data_in = 12'($urandom);
      if ($urandom_range(0, 15) == 0) bus.mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) bus.fade_div = 8'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if (obs() !== exp_out) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random cyc=%0d got=%b want=%b", k, obs(), exp_out);
      end
    end
    rst = 1'b0;
    bus.store = 1'b0;
  endtask

  initial begin
    bus.data_in = '0;
    bus.store = 1'b0;
    bus.mode = 2'b00;
    bus.fade_div = '0;
    test_reset();
    test_direct();
    test_fade_div0();
    test_fade_div2();
    test_store_on_wrap();
    test_blank_test_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
